// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for a 5-stage RV32 pipeline.
// Owns the fetch PC and issues in-order, word-aligned requests to instruction
// memory. Returned instructions land in a small prefetch FIFO and are handed
// to decode together with their PC. Redirects flush the FIFO, retarget both PC
// counters and discard every response still in flight from the old path.
module instruction_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter int              INSTR_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    // Request channel to instruction memory
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,

    // In-order response channel from instruction memory
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,

    // Control-flow redirect from a later stage
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,

    // Decode interface
    input  logic                   id_stall,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [XLEN-1:0]        if_pc
);

    // Counter width holds 0..FIFO_DEPTH inclusive; pointer width indexes the FIFO.
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    // Credit limit, one bit wider than the counters so the sum never wraps.
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);

    // Architectural PC step for fixed 32-bit instructions.
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]        fetch_pc;      // address of the next request
    logic [XLEN-1:0]        rsp_pc;        // PC of the next kept response
    logic [CW-1:0]          outstanding;   // accepted requests not yet answered
    logic [CW-1:0]          drop;          // responses still to be discarded

    logic [INSTR_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]        pc_q    [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                   credit_ok;
    logic                   req_fire;
    logic                   rsp_accept;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [CW-1:0]          outstanding_nxt;
    logic [XLEN-1:0]        redirect_aligned;

    // Credit counts requests in flight plus buffered entries; a pop in the
    // same cycle does not free a slot, keeping the request path off the
    // decode stall path.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIMIT;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is
    // ignored so the counters cannot underflow.
    assign rsp_accept = !rst && imem_rsp_valid && (outstanding != '0);

    // Responses are kept only when no discards are pending and the path is
    // not being redirected in this very cycle.
    assign push = rsp_accept && (drop == '0) && !redirect_valid;

    assign fifo_empty = (fifo_count == '0);
    assign pop        = !rst && !fifo_empty && !id_stall && !redirect_valid;

    assign outstanding_nxt  = outstanding + CW'(req_fire) - CW'(rsp_accept);
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------
    // PC counters, outstanding tracker and drop counter
    // ------------------------------------------------------------------
    // Advance fetch/response PCs and track in-flight and to-be-dropped requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the
                // abandoned path; repeated redirects simply re-capture it.
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                drop     <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (rsp_accept && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    // Maintain FIFO pointers and occupancy; reset and redirect both empty it.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write the returned instruction and its PC into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy is
        // tracked by fifo_count and empty slots are never presented.
        if (push) begin
            instr_q[wr_ptr] <= imem_rsp_data;
            pc_q[wr_ptr]    <= rsp_pc;
        end
    end

    // ------------------------------------------------------------------
    // Decode-side outputs
    // ------------------------------------------------------------------
    // Present the FIFO head to decode, zeroed whenever nothing is valid.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave one
        // unassigned and infer a latch.
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        if (!rst && !fifo_empty) begin
            if_valid = 1'b1;
            if_instr = instr_q[rd_ptr];
            if_pc    = pc_q[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Simulation check
    // ------------------------------------------------------------------
    // Flag a memory response that arrives with no request outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (default parameters).
// A small in-order memory model answers accepted requests one cycle later
// (or later while held). Inputs change and outputs are sampled just after
// the falling clock edge.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    // Memory model state
    logic        mem_hold;
    logic [31:0] pend_q[$];

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1357;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive the memory response, check the outputs, record
    // any accepted request, then advance to the next falling edge.
    task automatic run_cycle(input string tag, input logic exp_rv,
                             input logic [31:0] exp_addr, input logic exp_iv,
                             input logic [31:0] exp_pc);
        if (rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (!mem_hold && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        check({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check({tag, " req_addr"}, imem_req_addr, exp_addr);
        check({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, exp_iv});
        check({tag, " if_pc"}, if_pc, exp_iv ? exp_pc : 32'h0);
        check({tag, " if_instr"}, if_instr, exp_iv ? mem_word(exp_pc) : 32'h0);
        if (imem_req_valid && imem_req_ready && !rst) pend_q.push_back(imem_req_addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        mem_hold       = 1'b0;
        run_cycle("reset0", 1'b0, 32'h0, 1'b0, 32'h0);
        run_cycle("reset1", 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Streaming from reset (credit = outstanding + occupancy < 2), then a
        // five-cycle decode stall with a full FIFO and release.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h18};

        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_hold       = 1'b0;
        @(negedge clk);

        // Streaming and stall vectors
        do_reset();
        for (int i = 0; i < 17; i++) begin
            id_stall       = vecs[i].stall;
            imem_req_ready = vecs[i].ready;
            run_cycle($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr,
                      vecs[i].exp_iv, vecs[i].exp_pc);
        end

        // Redirect to a misaligned target with two requests outstanding
        do_reset();
        mem_hold = 1'b1;
        run_cycle("rd_c0", 1'b1, 32'h0, 1'b0, 32'h0);
        run_cycle("rd_c1", 1'b1, 32'h4, 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        run_cycle("rd_c2", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        run_cycle("rd_c3", 1'b0, 32'h0, 1'b0, 32'h0);
        run_cycle("rd_c4", 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        run_cycle("rd_c5", 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        run_cycle("rd_c6", 1'b0, 32'h0, 1'b1, 32'h0000_1000);
        run_cycle("rd_c7", 1'b1, 32'h0000_1008, 1'b1, 32'h0000_1004);

        // Redirect coinciding with a response and a would-be pop
        do_reset();
        run_cycle("rp_c0", 1'b1, 32'h0, 1'b0, 32'h0);
        run_cycle("rp_c1", 1'b1, 32'h4, 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        run_cycle("rp_c2", 1'b0, 32'h0, 1'b1, 32'h0);
        redirect_valid = 1'b0;
        run_cycle("rp_c3", 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        run_cycle("rp_c4", 1'b1, 32'h0000_0204, 1'b0, 32'h0);
        run_cycle("rp_c5", 1'b0, 32'h0, 1'b1, 32'h0000_0200);
        run_cycle("rp_c6", 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204);

        // Address wrap at the top of the address space, with a ready=0 cycle
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        run_cycle("wr_c0", 1'b0, 32'h0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        run_cycle("wr_c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        imem_req_ready = 1'b1;
        run_cycle("wr_c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run_cycle("wr_c3", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        run_cycle("wr_c4", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        run_cycle("wr_c5", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

        // Reset in the middle of a stalled stream with a request outstanding
        do_reset();
        id_stall = 1'b1;
        mem_hold = 1'b1;
        run_cycle("mr_c0", 1'b1, 32'h0, 1'b0, 32'h0);
        run_cycle("mr_c1", 1'b1, 32'h4, 1'b0, 32'h0);
        mem_hold = 1'b0;
        run_cycle("mr_c2", 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        run_cycle("mr_c3", 1'b0, 32'h0, 1'b0, 32'h0);
        run_cycle("mr_c4", 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        run_cycle("mr_c5", 1'b1, 32'h0, 1'b0, 32'h0);
        run_cycle("mr_c6", 1'b1, 32'h4, 1'b0, 32'h0);
        run_cycle("mr_c7", 1'b0, 32'h0, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
